// File: rtl/nasti_mem_tester.sv
// NASTI (AXI4) memory tester: writes NUM_BURSTS INCR bursts of an address-derived
// pattern, reads them back and counts errors. Define NASTI_MEM_TESTER_TIMEOUT_EN for the watchdog.
module nasti_mem_tester #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned NUM_BURSTS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic                    timeout,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [ID_WIDTH-1:0]     aw_id,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic [7:0]              aw_len,
  output logic [2:0]              aw_size,
  output logic [1:0]              aw_burst,
  output logic [USER_WIDTH-1:0]   aw_user,
  output logic                    w_valid,
  output logic                    w_last,
  input  logic                    w_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [ID_WIDTH-1:0]     b_id,
  input  logic [1:0]              b_resp,
  input  logic [USER_WIDTH-1:0]   b_user,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [ID_WIDTH-1:0]     ar_id,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic [7:0]              ar_len,
  output logic [2:0]              ar_size,
  output logic [1:0]              ar_burst,
  output logic [USER_WIDTH-1:0]   ar_user,
  input  logic                    r_valid,
  input  logic                    r_last,
  output logic                    r_ready,
  input  logic [ID_WIDTH-1:0]     r_id,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic [USER_WIDTH-1:0]   r_user
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned KW    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BW-1:0]         LAST_BEAT  = BW'(BURST_LEN - 1);
  localparam logic [KW-1:0]         LAST_BURST = KW'(NUM_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP  = ADDR_WIDTH'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [BW-1:0]           r_beat;
  logic [KW-1:0]           r_burst;
  logic                    r_busy, r_done;
  logic [15:0]             r_err;
  logic [DATA_WIDTH-1:0]   w_pattern;
  logic w_start_acc, w_last_beat, w_last_burst, w_err_inc, w_wd_fire;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_unused;

  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [31:0] a);
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < DATA_WIDTH / 32; i++)
      res[i*32 +: 32] = (a + 32'(i << 2)) ^ 32'hA5A5_5A5A;
    return res;
  endfunction

  assign w_unused = ^{b_id, b_user, r_id, r_user};

  // r_addr is the current beat address; after a full burst it is already the next burst base
  assign w_pattern    = f_pattern(32'(r_addr));
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_last_burst = (r_burst == LAST_BURST);
  assign w_start_acc  = start && (r_state == S_IDLE || r_state == S_DONE);

  assign aw_id    = '0;
  assign ar_id    = '0;
  assign aw_user  = '0;
  assign ar_user  = '0;
  assign aw_burst = 2'b01;
  assign ar_burst = 2'b01;
  assign aw_len   = 8'(BURST_LEN - 1);
  assign ar_len   = 8'(BURST_LEN - 1);
  assign aw_size  = 3'($clog2(BYTES));
  assign ar_size  = 3'($clog2(BYTES));
  assign aw_addr  = r_addr;
  assign ar_addr  = r_addr;
  assign w_data   = w_pattern;
  assign w_strb   = '1;

  assign w_aw_hs = aw_valid && aw_ready;
  assign w_w_hs  = w_valid && w_ready;
  assign w_b_hs  = b_valid && b_ready;
  assign w_ar_hs = ar_valid && ar_ready;
  assign w_r_hs  = r_valid && r_ready;

  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err;
  assign pass      = r_done && (r_err == '0);

`ifdef NASTI_MEM_TESTER_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_timeout;
  logic        w_wd_active;

  assign w_wd_active = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_wd_fire   = w_wd_active && (r_wdog == 16'hFFFF);
  assign timeout     = r_timeout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (w_start_acc) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs) begin
      r_wdog <= '0;
    end else if (w_wd_fire) begin
      r_wdog    <= '0;
      r_timeout <= 1'b1;
    end else if (w_wd_active) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  assign w_wd_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    w_last   = 1'b0;
    b_ready  = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_WR_ADDR;
      S_WR_ADDR: begin
        aw_valid = 1'b1;
        if (aw_ready) w_next = S_WR_DATA;
      end
      S_WR_DATA: begin
        w_valid = 1'b1;
        w_last  = w_last_beat;
        if (w_ready && w_last_beat) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        b_ready = 1'b1;
        if (b_valid) w_next = w_last_burst ? S_RD_ADDR : S_WR_ADDR;
      end
      S_RD_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        r_ready = 1'b1;
        if (r_valid && w_last_beat) w_next = w_last_burst ? S_DONE : S_RD_ADDR;
      end
      S_DONE:    w_next = start ? S_WR_ADDR : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    // Watchdog expiry abandons the transaction outright
    if (w_wd_fire) begin
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      w_last   = 1'b0;
      b_ready  = 1'b0;
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      w_next   = S_DONE;
    end
  end

  assign w_err_inc = (w_b_hs && (b_resp != 2'b00))
                   || (w_r_hs && ((r_data != w_pattern) || (r_resp != 2'b00)
                                  || (r_last != w_last_beat)))
                   || w_wd_fire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= BASE_ADDR;
      r_beat  <= '0;
      r_burst <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else if (w_start_acc) begin
      r_addr  <= BASE_ADDR;
      r_beat  <= '0;
      r_burst <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      if (w_err_inc && (r_err != 16'hFFFF)) r_err <= r_err + 16'd1;
      if (w_aw_hs || w_ar_hs) r_beat <= '0;
      if (w_w_hs || w_r_hs) begin
        r_addr <= r_addr + BEAT_STEP;
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
      if (w_b_hs) begin
        if (w_last_burst) begin
          r_burst <= '0;
          r_addr  <= BASE_ADDR;
        end else begin
          r_burst <= r_burst + 1'b1;
        end
      end
      if (w_r_hs && w_last_beat) r_burst <= r_burst + 1'b1;
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nasti_mem_tester.sv
// Directed bench for nasti_mem_tester: behavioural NASTI slave memory with
// fault/backpressure knobs, one task per scenario.
module tb_nasti_mem_tester;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass, timeout;
  logic [15:0] err_count;
  logic aw_valid, aw_ready;
  logic [0:0] aw_id, aw_user, ar_id, ar_user, b_id, b_user, r_id, r_user;
  logic [15:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size;
  logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
  logic w_valid, w_last, w_ready, b_valid, b_ready, ar_valid, ar_ready;
  logic r_valid, r_last, r_ready;
  logic [127:0] w_data, r_data;
  logic [15:0] w_strb;

  always #5 clk = ~clk;

  nasti_mem_tester #(
    .ID_WIDTH(1), .ADDR_WIDTH(16), .DATA_WIDTH(128), .USER_WIDTH(1),
    .BURST_LEN(8), .NUM_BURSTS(16), .BASE_ADDR(16'h0000)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout(timeout),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_user(aw_user),
    .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_user(ar_user),
    .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_user(r_user)
  );

  int n_checks = 0;
  int n_fail = 0;

  // slave knobs and observation counters
  bit bp, corrupt, bresp_err, rlast_all, aw_stuck;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, w_bad, stab_bad, rleft;
  logic [15:0] first_aw, last_ar, wa, ra, aw_snap, ar_snap;
  logic [127:0] w_snap;
  logic w_snap_last;
  bit pend_b, b_hs_prev, r_hs_prev, aw_stall, w_stall, ar_stall;
  logic [127:0] mem [0:4095];

  function automatic logic [127:0] pat(input logic [15:0] a);
    logic [127:0] res;
    logic [31:0] lane_addr;
    lane_addr = {16'h0000, a};
    for (int i = 0; i < 4; i++) begin
      res[i*32 +: 32] = lane_addr ^ 32'hA5A5_5A5A;
      lane_addr = lane_addr + 32'd4;
    end
    return res;
  endfunction

  function automatic bit coin();
    return bit'($urandom_range(0, 1));
  endfunction

  initial begin
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0; ar_ready = 0;
    r_valid = 0; r_data = '0; r_resp = 0; r_last = 0;
    b_id = 0; b_user = 0; r_id = 0; r_user = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0; r_last = 0;
        pend_b = 0; rleft = 0; b_hs_prev = 0; r_hs_prev = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0;
      end else begin
        if (aw_stall && (aw_valid !== 1'b1 || aw_addr !== aw_snap)) stab_bad++;
        if (w_stall && (w_valid !== 1'b1 || w_data !== w_snap || w_last !== w_snap_last)) stab_bad++;
        if (ar_stall && (ar_valid !== 1'b1 || ar_addr !== ar_snap)) stab_bad++;
        // B
        if (b_hs_prev) b_valid = 0;
        if (!b_valid && pend_b && (!bp || coin())) begin
          b_valid = 1; b_resp = bresp_err ? 2'b10 : 2'b00; pend_b = 0;
        end
        b_hs_prev = b_valid && b_ready;
        if (b_hs_prev) b_cnt++;
        // R
        if (r_hs_prev) r_valid = 0;
        if (!r_valid && rleft > 0 && (!bp || coin())) begin
          r_valid = 1;
          r_data = mem[ra[15:4]];
          if (corrupt && (r_cnt / 8) == 2 && (r_cnt % 8) == 3) r_data[0] = ~r_data[0];
          r_last = rlast_all || ((r_cnt % 8) == 7);
          r_resp = 0;
        end
        r_hs_prev = r_valid && r_ready;
        if (r_hs_prev) begin r_cnt++; ra += 16'd16; rleft--; end
        // AW
        aw_ready = aw_stuck ? 1'b0 : (bp ? coin() : 1'b1);
        if (aw_valid && aw_ready) begin
          if (aw_cnt == 0) first_aw = aw_addr;
          aw_cnt++; wa = aw_addr;
        end
        aw_stall = aw_valid && !aw_ready; aw_snap = aw_addr;
        // W
        w_ready = bp ? coin() : 1'b1;
        if (w_valid && w_ready) begin
          if (w_data !== pat(wa) || w_last !== ((w_cnt % 8) == 7)) w_bad++;
          mem[wa[15:4]] = w_data; wa += 16'd16; w_cnt++;
          if (w_last) pend_b = 1;
        end
        w_stall = w_valid && !w_ready; w_snap = w_data; w_snap_last = w_last;
        // AR
        ar_ready = bp ? coin() : 1'b1;
        if (ar_valid && ar_ready) begin
          ar_cnt++; last_ar = ar_addr; ra = ar_addr; rleft = 8;
        end
        ar_stall = ar_valid && !ar_ready; ar_snap = ar_addr;
      end
    end
  end

  task automatic clear_counts();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; w_bad = 0; stab_bad = 0;
    first_aw = 16'hFFFF; last_ar = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      ok = (done === 1'b1);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, busy, done, pass, timeout} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=0", {aw_valid, w_valid, b_ready, ar_valid, r_ready, busy, done, pass, timeout});
    end
    n_checks++;
    if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err got=%0h exp=0", err_count); end
    @(negedge clk); #2; rstn = 1'b1;
  endtask

  task automatic test_ideal();
    bit ok;
    clear_counts();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || aw_valid !== 1'b1 || aw_addr !== 16'h0000 || done !== 1'b0) begin
      n_fail++; $display("FAIL ideal_first_aw got busy=%b awv=%b addr=%0h done=%b exp 1 1 0 0", busy, aw_valid, aw_addr, done);
    end
    n_checks++;
    if ({aw_len, aw_size, aw_burst, aw_id, aw_user} !== {8'd7, 3'd4, 2'b01, 1'b0, 1'b0} || w_strb !== 16'hFFFF) begin
      n_fail++; $display("FAIL ideal_aw_const got len=%0d size=%0d burst=%0d strb=%0h", aw_len, aw_size, aw_burst, w_strb);
    end
    @(posedge clk); #1;
    n_checks++;
    if (aw_valid !== 1'b0 || w_valid !== 1'b1 || w_last !== 1'b0) begin
      n_fail++; $display("FAIL ideal_aw_drop got awv=%b wv=%b wl=%b exp 0 1 0", aw_valid, w_valid, w_last);
    end
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (r_cnt == 128);
    end
    n_checks++;
    if (!ok || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ideal_final_r got reached=%0d done=%b busy=%b exp 1 0 1", ok, done, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL ideal_done got done=%b busy=%b pass=%b err=%0d exp 1 0 1 0", done, busy, pass, err_count);
    end
    n_checks++;
    if (aw_cnt != 16 || w_cnt != 128 || b_cnt != 16 || ar_cnt != 16 || r_cnt != 128) begin
      n_fail++; $display("FAIL ideal_counts got aw=%0d w=%0d b=%0d ar=%0d r=%0d exp 16 128 16 16 128", aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt);
    end
    n_checks++;
    if (first_aw !== 16'h0000 || last_ar !== 16'h0780) begin
      n_fail++; $display("FAIL ideal_addr got first_aw=%0h last_ar=%0h exp 0 780", first_aw, last_ar);
    end
    n_checks++;
    if (w_bad != 0) begin n_fail++; $display("FAIL ideal_wdata got bad=%0d exp 0", w_bad); end
  endtask

  task automatic test_corrupt();
    bit ok;
    clear_counts();
    corrupt = 1;
    pulse_start();
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(3000, ok);
    n_checks++;
    if (!ok || err_count !== 16'd1 || pass !== 1'b0) begin
      n_fail++; $display("FAIL corrupt_err got done=%0d err=%0d pass=%b exp 1 1 0", ok, err_count, pass);
    end
    n_checks++;
    if (aw_cnt != 16) begin n_fail++; $display("FAIL start_while_busy got aw=%0d exp 16", aw_cnt); end
    corrupt = 0;
  endtask

  task automatic test_bresp_rlast();
    bit ok;
    clear_counts();
    bresp_err = 1; rlast_all = 1;
    pulse_start();
    wait_done(3000, ok);
    // 16 error responses + 7 early r_last per 8-beat burst * 16 bursts
    n_checks++;
    if (!ok || err_count !== 16'd128 || pass !== 1'b0) begin
      n_fail++; $display("FAIL bresp_rlast_err got done=%0d err=%0d pass=%b exp 1 128 0", ok, err_count, pass);
    end
    bresp_err = 0; rlast_all = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_counts();
    bp = 1;
    pulse_start();
    wait_done(10000, ok);
    n_checks++;
    if (!ok || pass !== 1'b1 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL bp_pass got done=%0d pass=%b err=%0d exp 1 1 0", ok, pass, err_count);
    end
    n_checks++;
    if (stab_bad != 0 || w_bad != 0) begin
      n_fail++; $display("FAIL bp_stable got stab=%0d wbad=%0d exp 0 0", stab_bad, w_bad);
    end
    n_checks++;
    if (aw_cnt != 16 || r_cnt != 128 || last_ar !== 16'h0780) begin
      n_fail++; $display("FAIL bp_counts got aw=%0d r=%0d last_ar=%0h exp 16 128 780", aw_cnt, r_cnt, last_ar);
    end
    bp = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_counts();
    pulse_start();
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (w_cnt == 5);
    end
    @(posedge clk); #2;
    n_checks++;
    if (!ok || w_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_state got reached=%0d wv=%b busy=%b exp 1 1 1", ok, w_valid, busy);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, busy, done, pass, timeout} !== 9'b0 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset got ctrl=%b err=%0d exp 0 0", {aw_valid, w_valid, b_ready, ar_valid, r_ready, busy, done, pass, timeout}, err_count);
    end
    repeat (2) @(negedge clk);
    #2; rstn = 1'b1;
    @(negedge clk); #1;
    clear_counts();
    pulse_start();
    wait_done(3000, ok);
    n_checks++;
    if (!ok || pass !== 1'b1 || w_cnt != 128 || r_cnt != 128 || aw_cnt != 16 || w_bad != 0) begin
      n_fail++; $display("FAIL mid_rerun got done=%0d pass=%b w=%0d r=%0d aw=%0d wbad=%0d", ok, pass, w_cnt, r_cnt, aw_cnt, w_bad);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    clear_counts();
    aw_stuck = 1;
    pulse_start();
`ifdef NASTI_MEM_TESTER_TIMEOUT_EN
    n = 1;
    ok = (done === 1'b1);
    while (!ok && n < 70000) begin
      @(negedge clk); #1;
      n++;
      ok = (done === 1'b1);
    end
    n_checks++;
    if (!ok || n != 65537) begin n_fail++; $display("FAIL wdog_latency got cycles=%0d exp 65537", n); end
    n_checks++;
    if (timeout !== 1'b1 || err_count !== 16'd1 || busy !== 1'b0 || aw_valid !== 1'b0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL wdog_state got to=%b err=%0d busy=%b awv=%b pass=%b exp 1 1 0 0 0", timeout, err_count, busy, aw_valid, pass);
    end
    aw_stuck = 0;
    pulse_start();
    n_checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wdog_clear got to=%b busy=%b exp 0 1", timeout, busy);
    end
    wait_done(3000, ok);
    n_checks++;
    if (!ok || pass !== 1'b1) begin n_fail++; $display("FAIL wdog_rerun got done=%0d pass=%b exp 1 1", ok, pass); end
`else
    repeat (300) @(negedge clk);
    #1;
    n = 0;
    ok = 0;
    n_checks++;
    if (busy !== 1'b1 || timeout !== 1'b0 || aw_valid !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL stuck_aw got busy=%b to=%b awv=%b done=%b exp 1 0 1 0", busy, timeout, aw_valid, done);
    end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #2; rstn = 1'b1;
    aw_stuck = 0;
    @(negedge clk); #1;
`endif
  endtask

  initial begin
    bp = 0; corrupt = 0; bresp_err = 0; rlast_all = 0; aw_stuck = 0;
    clear_counts();
    test_reset();
    test_ideal();
    test_corrupt();
    test_bresp_rlast();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nasti_mem_tester.md
Name: nasti_mem_tester

Overview:
- NASTI (AXI4) master/initiator that exercises a NASTI slave memory, e.g. the DPI-backed behavioural RAM or a real controller.
- On start, it writes NUM_BURSTS incrementing bursts of a deterministic address-derived pattern, then reads the same region back and compares each beat.
- Reports done, pass and an error count. Used in simulation and FPGA bring-up benches as the driver for memory slaves.

Parameters:
- ID_WIDTH, 1, width of aw_id/ar_id/b_id/r_id.
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 128, data bus width in bits; power of two, 32..256.
- USER_WIDTH, 1, width of user sidebands.
- BURST_LEN, 8, beats per burst, 1..256.
- NUM_BURSTS, 16, bursts per pass, >=1.
- BASE_ADDR, 0, start byte address; aligned to DATA_WIDTH/8.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a test; ignored while busy.
- busy  output  1  test in progress.
- done  output  1  high from test completion until the next accepted start.
- pass  output  1  done && err_count==0.
- err_count  output  16  saturating error count.
- timeout  output  1  watchdog fired (see Optional Feature).
- aw_valid  output  1  write address valid.
- aw_ready  input  1  write address ready.
- aw_id/aw_addr/aw_len/aw_size/aw_burst/aw_user  output  ID/ADDR/8/3/2/USER  AW payload.
- w_valid, w_last  output  1 each  W valid; last beat of burst.
- w_ready  input  1  W ready.
- w_data/w_strb  output  DATA/DATA/8  W payload.
- b_valid  input  1  write response valid.
- b_ready  output  1  write response ready.
- b_id/b_resp/b_user  input  ID/2/USER  B payload.
- ar_valid  output  1  read address valid.
- ar_ready  input  1  read address ready.
- ar_id/ar_addr/ar_len/ar_size/ar_burst/ar_user  output  ID/ADDR/8/3/2/USER  AR payload.
- r_valid, r_last  input  1 each  R valid; last beat.
- r_ready  output  1  R ready.
- r_id/r_data/r_resp/r_user  input  ID/DATA/2/USER  R payload.

Behaviour:
- Reset (asynchronous): every valid/ready output is 0; busy, done, pass and timeout are 0; err_count is 0; FSM is in IDLE. Reset mid-burst abandons the transaction immediately.
- Constant fields: aw_id=ar_id=0, aw_user=ar_user=0, aw_burst=ar_burst=2'b01 (INCR), aw_len=ar_len=BURST_LEN-1, aw_size=ar_size=log2(DATA_WIDTH/8), w_strb all ones.
- Burst addressing: burst k (0..NUM_BURSTS-1) address = BASE_ADDR + k*BURST_LEN*(DATA_WIDTH/8), truncated to ADDR_WIDTH.
- Pattern: for the beat at byte address A, 32-bit lane i = (A + 4*i) XOR 32'hA5A5_5A5A, with 32-bit wrap.
- Only one transaction is outstanding at a time. Valid never depends on ready. Once valid rises, payload and valid hold until the handshake (valid && ready in the same cycle).
- FSM transitions:
  - IDLE: start -> WR_ADDR; on that edge busy=1, done=0, err_count=0, k=0.
  - WR_ADDR: aw_valid=1; on AW handshake -> WR_DATA with beat=0. aw_valid must be seen as 0 on the following cycle.
  - WR_DATA: w_valid=1; w_last=(beat==BURST_LEN-1); on a W handshake, beat++. A handshake on the last beat -> WR_RESP.
  - WR_RESP: b_ready=1; on a B handshake with b_resp!=0, err++. Then if k==NUM_BURSTS-1 -> RD_ADDR with k=0, else k++ and -> WR_ADDR.
  - RD_ADDR: ar_valid=1; handshake -> RD_DATA with beat=0.
  - RD_DATA: r_ready=1; each R handshake counts exactly one error if any of these hold: data mismatch, r_resp!=0, r_last!=(beat==BURST_LEN-1). The burst ends on the beat==BURST_LEN-1 handshake, regardless of r_last. Then k++ -> RD_ADDR, or after the last burst -> DONE.
  - DONE: busy=0, done=1 (registered, visible the cycle after the final R handshake) -> IDLE.
- err_count saturates at 16'hFFFF.
- b_id/r_id/user inputs are ignored.
- BURST_LEN=1: every W beat is last, and each burst is a single-beat transaction.

Optional Feature:
- Macro: NASTI_MEM_TESTER_TIMEOUT_EN.
- With the macro defined: a 16-bit watchdog is cleared on every handshake and on start, and increments each cycle in any WR_*/RD_* state. On reaching 16'hFFFF, err++, timeout=1, all valids/readies drop, and the FSM goes to DONE. timeout clears on the next accepted start.
- Without the macro: no watchdog logic; timeout is tied to 0.

Test Plan:
1. Ideal slave (ready always 1, OKAY), defaults, start pulse -> 16 AW + 128 W + 16 B, then 16 AR + 128 R; done=1, pass=1, err_count=0. First aw_addr=0x0000, last ar_addr=0x0780.
2. Slave corrupts bit 0 of read beat 3 in burst 2 -> err_count=1, pass=0.
3. Slave returns b_resp=2'b10 on every write and r_last on every beat with BURST_LEN=4 -> err_count=16 (B) + 48 (early r_last) = 64.
4. Random ready backpressure (50%) on AW/W/AR plus a random r_valid/b_valid gap -> payload stable while valid && !ready; pass=1.
5. rstn low during WR_DATA beat 5 -> all outputs 0 asynchronously; after release, start -> clean full pass=1.
6. Timeout build, aw_ready stuck at 0 -> after 65535 cycles timeout=1, done=1, err_count=1; without the macro, busy stays 1 and timeout=0.
